// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// State encodings, domain limit and timer width function.
package rst_seq_pkg;

    // Visible on state_o, so the encodings are fixed.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT_RST  = 3'd4
    } rst_seq_state_e;

    localparam int MAX_DOMAINS = 8;

    // One timer serves every state, so it must hold the
    // larger of the two terminal counts.
    function automatic int rst_seq_cnt_w(input int a,
                                         input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared cycle timer for the reset sequencer.
// Ports: clk_i, rst_i, clr_i (sync clear), en_i (count),
//        tc_i (terminal count), done_o (count == tc_i).
module rst_seq_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             done_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign done_o = (r_cnt == tc_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up / warm reset sequencer: qualifies PLL lock, then
// enables clocks and releases per-domain resets in order.
// Ports: clk_i, rst_i, lock_i, pll_bps_i, testmode_i,
//        sw_rst_i, lost_clr_i -> clk_en_o, rstn_o, ready_o,
//        lock_lost_o, state_o.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STEP_CYCLES        = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lock_i,
    input  logic                   pll_bps_i,
    input  logic                   testmode_i,
    input  logic                   sw_rst_i,
    input  logic                   lost_clr_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] rstn_o,
    output logic                   ready_o,
    output logic                   lock_lost_o,
    output logic [2:0]             state_o
);

    localparam int CNT_W =
        rst_seq_cnt_w(LOCK_STABLE_CYCLES, STEP_CYCLES);
    localparam int IDX_W = $clog2(MAX_DOMAINS);

    localparam logic [CNT_W-1:0] TC_STABLE =
        CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_STEP =
        CNT_W'(STEP_CYCLES - 1);

    rst_seq_state_e r_state;
    rst_seq_state_e w_state_nxt;

    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_clk_en;
    logic [NUM_DOMAINS-1:0] w_clk_en_nxt;
    logic [NUM_DOMAINS-1:0] r_rstn;
    logic [NUM_DOMAINS-1:0] w_rstn_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;
    logic                   r_lost;
    logic                   w_lost_set;

    logic                   w_bypass;
    logic                   w_lock_eff;
    logic                   w_last;
    logic [NUM_DOMAINS-1:0] w_sel;
    logic [NUM_DOMAINS-1:0] w_sel_nxt;

    logic                   w_tmr_clr;
    logic                   w_tmr_en;
    logic [CNT_W-1:0]       w_tmr_tc;
    logic                   w_tmr_done;

    assign w_bypass   = pll_bps_i | testmode_i;
    assign w_lock_eff = lock_i | w_bypass;
    assign w_last     = (int'(r_idx) == NUM_DOMAINS - 1);

    // One-hot masks for the current and the following step.
    always_comb begin
        w_sel     = '0;
        w_sel_nxt = '0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            w_sel[k]     = (int'(r_idx) == k);
            w_sel_nxt[k] = (int'(r_idx) + 1 == k);
        end
    end

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_tmr_clr),
        .en_i   (w_tmr_en),
        .tc_i   (w_tmr_tc),
        .done_o (w_tmr_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_WAIT_LOCK;
            r_idx    <= '0;
            r_clk_en <= '0;
            r_rstn   <= '0;
            r_ready  <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_rstn   <= w_rstn_nxt;
            r_ready  <= w_ready_nxt;
            // A new loss beats a clear in the same cycle.
            if (w_lost_set) begin
                r_lost <= 1'b1;
            end else if (lost_clr_i) begin
                r_lost <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_clk_en_nxt = r_clk_en;
        w_rstn_nxt   = r_rstn;
        w_ready_nxt  = r_ready;
        w_lost_set   = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        w_tmr_tc     = TC_STEP;

        unique case (r_state)
            ST_WAIT_LOCK: begin
                w_tmr_clr = 1'b1;
                if (w_lock_eff) begin
                    // Bypass/test clocks need no settling.
                    if (w_bypass) begin
                        w_state_nxt     = ST_RELEASE;
                        w_idx_nxt       = '0;
                        w_clk_en_nxt[0] = 1'b1;
                    end else begin
                        w_state_nxt = ST_STABLE;
                    end
                end
            end

            ST_STABLE: begin
                w_tmr_tc = TC_STABLE;
                if (!w_lock_eff) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_tmr_clr   = 1'b1;
                end else if (w_tmr_done) begin
                    w_state_nxt     = ST_RELEASE;
                    w_idx_nxt       = '0;
                    w_clk_en_nxt[0] = 1'b1;
                    w_tmr_clr       = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_RELEASE: begin
                w_clk_en_nxt = r_clk_en | w_sel;
                if (w_tmr_done) begin
                    w_tmr_clr  = 1'b1;
                    w_rstn_nxt = r_rstn | w_sel;
                    if (w_last) begin
                        w_state_nxt = ST_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        // Next clock starts with its step.
                        w_idx_nxt    = r_idx + IDX_W'(1);
                        w_clk_en_nxt = r_clk_en | w_sel
                                     | w_sel_nxt;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_RUN: begin
                if (sw_rst_i) begin
                    w_state_nxt = ST_SOFT_RST;
                    w_rstn_nxt  = '0;
                    w_ready_nxt = 1'b0;
                    w_tmr_clr   = 1'b1;
                end
            end

            ST_SOFT_RST: begin
                // Clocks keep running through the hold.
                if (w_tmr_done) begin
                    w_state_nxt = ST_RELEASE;
                    w_idx_nxt   = '0;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = ST_WAIT_LOCK;
                w_idx_nxt    = '0;
                w_clk_en_nxt = '0;
                w_rstn_nxt   = '0;
                w_ready_nxt  = 1'b0;
                w_tmr_clr    = 1'b1;
            end
        endcase

        // Lock loss overrides step completion and sw reset.
        if (!w_lock_eff &&
            (r_state == ST_RELEASE ||
             r_state == ST_RUN ||
             r_state == ST_SOFT_RST)) begin
            w_state_nxt  = ST_WAIT_LOCK;
            w_idx_nxt    = '0;
            w_clk_en_nxt = '0;
            w_rstn_nxt   = '0;
            w_ready_nxt  = 1'b0;
            w_lost_set   = 1'b1;
            w_tmr_clr    = 1'b1;
            w_tmr_en     = 1'b0;
        end
    end

    assign clk_en_o    = r_clk_en;
    assign rstn_o      = r_rstn;
    assign ready_o     = r_ready;
    assign lock_lost_o = r_lost;
    assign state_o     = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios
// plus random stimulus against a phase/elapsed-time model.
module tb_rst_seq_ctrl;

    localparam int ND   = 4;
    localparam int LSC  = 16;
    localparam int STEP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock = 1'b0;
    logic          bps = 1'b0;
    logic          tm = 1'b0;
    logic          sw = 1'b0;
    logic          clr = 1'b0;
    logic [ND-1:0] clk_en_o;
    logic [ND-1:0] rstn_o;
    logic          ready_o;
    logic          lock_lost_o;
    logic [2:0]    state_o;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase, cycles elapsed in phase, clocks
    // already on at phase start, sticky loss flag.
    int            m_mode = 0;
    int            m_t = 0;
    logic [ND-1:0] m_pre = '0;
    logic          m_lost = 1'b0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_DOMAINS        (ND),
        .LOCK_STABLE_CYCLES (LSC),
        .STEP_CYCLES        (STEP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lock_i      (lock),
        .pll_bps_i   (bps),
        .testmode_i  (tm),
        .sw_rst_i    (sw),
        .lost_clr_i  (clr),
        .clk_en_o    (clk_en_o),
        .rstn_o      (rstn_o),
        .ready_o     (ready_o),
        .lock_lost_o (lock_lost_o),
        .state_o     (state_o)
    );

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, act, exp);
        end
    endtask

    function automatic logic [ND-1:0] lo_mask(input int n);
        logic [ND-1:0] m;
        m = '0;
        for (int i = 0; i < ND; i++)
            if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_step();
        logic eff;
        logic byp;
        logic loss;
        byp  = bps | tm;
        eff  = lock | byp;
        loss = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_t    = 0;
            m_pre  = '0;
            m_lost = 1'b0;
            return;
        end
        if (clr) m_lost = 1'b0;
        case (m_mode)
            0: if (eff) begin
                m_mode = byp ? 2 : 1;
                m_t    = 0;
                m_pre  = '0;
            end
            1: if (!eff) begin
                m_mode = 0;
                m_t    = 0;
            end else begin
                m_t++;
                if (m_t == LSC) begin
                    m_mode = 2;
                    m_t    = 0;
                end
            end
            2: if (!eff) loss = 1'b1;
            else begin
                m_t++;
                if (m_t == ND * STEP) begin
                    m_mode = 3;
                    m_t    = 0;
                end
            end
            3: if (!eff) loss = 1'b1;
            else if (sw) begin
                m_mode = 4;
                m_t    = 0;
            end
            4: if (!eff) loss = 1'b1;
            else begin
                m_t++;
                if (m_t == STEP) begin
                    m_mode = 2;
                    m_t    = 0;
                    m_pre  = '1;
                end
            end
            default: m_mode = 0;
        endcase
        if (loss) begin
            m_mode = 0;
            m_t    = 0;
            m_pre  = '0;
            m_lost = 1'b1;
        end
    endtask

    task automatic compare();
        logic [ND-1:0] e_clk;
        logic [ND-1:0] e_rstn;
        logic          e_rdy;
        int            k;
        e_clk  = '0;
        e_rstn = '0;
        e_rdy  = 1'b0;
        case (m_mode)
            2: begin
                k      = m_t / STEP;
                e_clk  = m_pre | lo_mask(k + 1);
                e_rstn = lo_mask(k);
            end
            3: begin
                e_clk  = '1;
                e_rstn = '1;
                e_rdy  = 1'b1;
            end
            4: e_clk = '1;
            default: ;
        endcase
        chk("clk_en", 32'(clk_en_o), 32'(e_clk));
        chk("rstn", 32'(rstn_o), 32'(e_rstn));
        chk("ready", 32'(ready_o), 32'(e_rdy));
        chk("lost", 32'(lock_lost_o), 32'(m_lost));
        chk("state", 32'(state_o), 32'(m_mode));
        chk("inv", 32'(rstn_o & ~clk_en_o), 32'd0);
        assert ((rstn_o & ~clk_en_o) == '0)
            else $error("rstn without clock enable");
    endtask

    task automatic tick(input logic r, input logic lk,
                        input logic bp, input logic t,
                        input logic s, input logic c);
        @(negedge clk);
        rst  = r;
        lock = lk;
        bps  = bp;
        tm   = t;
        sw   = s;
        clr  = c;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
    endtask

    // Count cycles from the first tick to the first
    // clock enable, reset release and ready.
    task automatic measure(input logic lk, input logic bp,
                           input logic s,
                           output int n_en0,
                           output int n_rn0,
                           output int n_rdy);
        n_en0 = -1;
        n_rn0 = -1;
        n_rdy = -1;
        for (int n = 1; n <= 80; n++) begin
            tick(0, lk, bp, 0, (n == 1) ? s : 1'b0, 0);
            if (n_en0 < 0 && clk_en_o[0]) n_en0 = n;
            if (n_rn0 < 0 && rstn_o[0]) n_rn0 = n;
            if (n_rdy < 0 && ready_o) n_rdy = n;
            if (n_rdy >= 0) break;
        end
    endtask

    initial begin
        int a;
        int b;
        int c;

        // Scenario 1: normal lock.
        do_reset();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_clk_en", 32'(clk_en_o), 32'd0);
        measure(1, 0, 0, a, b, c);
        chk("s1_en0", a, 17);
        chk("s1_rstn0", b, 25);
        chk("s1_ready", c, 49);

        // Scenario 2: glitch during qualification.
        do_reset();
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        measure(1, 0, 0, a, b, c);
        chk("s2_en0", a, 17);
        chk("s2_ready", c, 49);

        // Scenario 3: PLL bypass.
        do_reset();
        measure(0, 1, 0, a, b, c);
        chk("s3_en0", a, 1);
        chk("s3_rstn0", b, 9);
        chk("s3_ready", c, 33);

        // Scenario 4: lock loss in RUN, clear, relock.
        tick(0, 0, 0, 0, 0, 0);
        chk("s4_lost", 32'(lock_lost_o), 32'd1);
        chk("s4_clk_en", 32'(clk_en_o), 32'd0);
        tick(0, 0, 0, 0, 0, 1);
        chk("s4_clr", 32'(lock_lost_o), 32'd0);
        measure(1, 0, 0, a, b, c);
        chk("s4_en0", a, 17);
        chk("s4_ready", c, 49);

        // Scenario 5: warm reset from RUN.
        measure(1, 0, 1, a, b, c);
        chk("s5_rstn0", b, 17);
        chk("s5_ready", c, 41);

        // Scenario 6a: reset mid-release at idx 2.
        do_reset();
        for (int i = 0; i < 35; i++) tick(0, 1, 0, 0, 0, 0);
        chk("s6_idx2_en", 32'(clk_en_o), 32'h7);
        tick(1, 1, 0, 0, 0, 0);
        chk("s6_rst_rstn", 32'(rstn_o), 32'd0);

        // Scenario 6b: sw reset coinciding with loss.
        measure(1, 0, 0, a, b, c);
        tick(0, 0, 0, 0, 1, 0);
        chk("s6_loss_state", 32'(state_o), 32'd0);
        chk("s6_loss_flag", 32'(lock_lost_o), 32'd1);
        // Loss and clear together: loss wins.
        measure(0, 1, 0, a, b, c);
        tick(0, 0, 0, 0, 0, 1);
        chk("s6_loss_clr", 32'(lock_lost_o), 32'd1);

        // Random stimulus.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 400) == 0,
                 ($urandom % 80) != 0,
                 ($urandom % 60) == 0,
                 ($urandom % 90) == 0,
                 ($urandom % 20) == 0,
                 ($urandom % 16) == 0);
        end

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Power-up and reset sequencer for the core clock/reset generation path. It waits for the PLL to lock, or for a bypass condition, and then qualifies lock stability. After that it enables the clock and releases the reset of each of NUM_DOMAINS downstream domains in a fixed order, one step at a time. It also handles PLL lock loss and a software-requested warm reset, and drives the per-domain clock-enable and active-low reset inputs of the clock/reset generators.

Parameters:
NUM_DOMAINS, 4, number of sequenced domains (1..8); domain 0 is released first.
LOCK_STABLE_CYCLES, 16, consecutive cycles lock must stay high before release starts (>=1).
STEP_CYCLES, 8, cycles per domain release step and soft-reset hold time (>=1).
CNT_W, $clog2(max(LOCK_STABLE_CYCLES,STEP_CYCLES)+1), shared timer width; derived, not overridden.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
lock_i  in  1  PLL lock, already synchronous to clk_i
pll_bps_i  in  1  PLL bypass; counts as permanent lock
testmode_i  in  1  scan/test mode; counts as permanent lock
sw_rst_i  in  1  single-cycle warm reset request
lost_clr_i  in  1  clears lock_lost_o
clk_en_o  out  NUM_DOMAINS  per-domain clock enable
rstn_o  out  NUM_DOMAINS  per-domain active-low reset
ready_o  out  1  all domains released (state RUN)
lock_lost_o  out  1  sticky lock-loss flag
state_o  out  3  current FSM state encoding (debug)

Behaviour:
- All logic is synchronous to clk_i. All outputs are registered (Moore). rst_i is synchronous active-high.
- Values under rst_i: state=WAIT_LOCK, timer=0, idx=0, clk_en_o=0, rstn_o=0, ready_o=0, lock_lost_o=0.
- lock_eff = lock_i | pll_bps_i | testmode_i.
- States and encodings: WAIT_LOCK(0), STABLE(1), RELEASE(2), RUN(3), SOFT_RST(4).
- WAIT_LOCK:
  - lock_eff=1 with pll_bps_i|testmode_i set -> RELEASE, idx=0, timer=0. There is no PLL to settle.
  - lock_eff=1 from lock_i alone -> STABLE, timer=0.
- STABLE:
  - lock_eff=0 -> WAIT_LOCK, timer=0. The stability count restarts from zero.
  - Otherwise the timer increments. When timer==LOCK_STABLE_CYCLES-1 -> RELEASE, idx=0, timer=0.
- RELEASE, step idx, lasting STEP_CYCLES cycles:
  - clk_en_o[idx]=1 from the first cycle of the step.
  - On the last cycle of the step (timer==STEP_CYCLES-1): rstn_o[idx] is set, visible on the next cycle, and timer resets to 0.
  - If idx==NUM_DOMAINS-1 -> RUN, ready_o=1 from the same cycle rstn_o[idx] rises. Otherwise idx increments.
  - Result: each clock runs STEP_CYCLES cycles under reset before its reset releases.
- RUN: holds. clk_en_o=all 1s, rstn_o=all 1s.
- sw_rst_i in RUN -> SOFT_RST, timer=0:
  - rstn_o=0 and ready_o=0 on the next cycle; clk_en_o stays all 1s.
  - After STEP_CYCLES cycles -> RELEASE, idx=0.
  - Already-enabled clocks stay enabled; the release of rstn_o is re-sequenced as normal.
- sw_rst_i in any state other than RUN is ignored.
- Lock loss: lock_eff=0 in RELEASE, RUN or SOFT_RST:
  - Next cycle: rstn_o=0, clk_en_o=0, ready_o=0, lock_lost_o=1, state=WAIT_LOCK, idx=0, timer=0.
  - Lock loss has priority over sw_rst_i and over step completion in the same cycle.
- lock_lost_o is sticky:
  - Cleared by lost_clr_i or rst_i.
  - A new loss in the same cycle as lost_clr_i wins (flag stays 1).
- Reset mid-sequence: rst_i in any state returns immediately to the reset values. No partial release survives.
- rstn_o[k]=1 implies clk_en_o[k]=1 at all times. This is an invariant and is asserted in the bench.
- The timer never exceeds max(LOCK_STABLE_CYCLES,STEP_CYCLES)-1. idx never exceeds NUM_DOMAINS-1.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum typedef rst_seq_state_e (3 bits, the encodings above);
  - localparam MAX_DOMAINS=8;
  - a function computing CNT_W.
- One sub-module, rst_seq_timer: CNT_W-bit counter with sync clear, enable and a terminal-count compare input. It is shared by the STABLE, RELEASE and SOFT_RST states.
- The FSM, idx register and output registers stay in rst_seq_ctrl.

Test Plan:
1. Defaults; rst_i released, lock_i rises at cycle T -> STABLE T+1..T+16; clk_en_o[0] at T+17; rstn_o[0..3] rise at T+25, T+33, T+41, T+49; ready_o=1 at T+49.
2. lock_i high 10 cycles, low 1 cycle, high again at cycle U -> no clk_en_o until U+17; lock_lost_o stays 0, because the loss occurred before RELEASE.
3. pll_bps_i=1, lock_i=0 from reset release at cycle T -> STABLE skipped; clk_en_o[0] at T+1; ready_o at T+33.
4. In RUN, lock_i drops at cycle V -> at V+1 rstn_o=0000, clk_en_o=0000, ready_o=0, lock_lost_o=1; lost_clr_i pulse clears the flag; relock re-runs scenario 1 timing.
5. In RUN, sw_rst_i pulse at cycle W -> rstn_o=0000 at W+1 with clk_en_o=1111; rstn_o[0] rises at W+17; ready_o at W+41.
6. rst_i asserted mid-RELEASE (idx=2), and separately sw_rst_i coinciding with lock loss -> reset values next cycle; lock-loss path taken, not SOFT_RST; invariant rstn_o[k]->clk_en_o[k] holds throughout.
